// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and default sizes for the physical-memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_port_t  : requester identifier (instruction / main-data adaptor)
//   *_DEF       : default parameter values (256-bit line = 4 x 64-bit beats)
package pmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 64;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_MAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_MAIN = 1'b1
  } arb_port_t;

  // Granted FSM state for a given winning port.
  function automatic arb_state_t port2state(input arb_port_t p);
    return (p == PORT_MAIN) ? ARB_MAIN : ARB_INST;
  endfunction

endpackage

// File: rtl/pmem_arb_grant.sv
// pmem_arb_grant: picks the winner between the instruction and main requesters.
// Build option: PMEM_ARB_ROUND_ROBIN_EN
//   defined   -> on a tie the port not granted last wins; pointer updates on
//                every grant, resets to "last = main" so inst wins first tie.
//   undefined -> fixed priority, main beats inst on a tie; no pointer state.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   i_req_inst    inst requester has read or write raised
//   i_req_main    main requester has read or write raised
//   i_grant_en    a grant is being issued this cycle (pointer update strobe)
//   o_winner      selected port (only meaningful when a request is present)
module pmem_arb_grant
  import pmem_arb_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      i_req_inst,
  input  logic      i_req_main,
  input  logic      i_grant_en,
  output arb_port_t o_winner
);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  arb_port_t r_last;

  always_ff @(posedge CLK) begin
    if (RST)             r_last <= PORT_MAIN;
    else if (i_grant_en) r_last <= o_winner;
  end

  always_comb begin
    o_winner = PORT_INST;
    if (i_req_inst && i_req_main)
      o_winner = (r_last == PORT_MAIN) ? PORT_INST : PORT_MAIN;
    else if (i_req_main)
      o_winner = PORT_MAIN;
  end
`else
  // Fixed priority needs no state; clock/reset/strobe are intentionally idle.
  logic w_unused;
  assign w_unused = ^{CLK, RST, i_grant_en, i_req_inst};

  assign o_winner = i_req_main ? PORT_MAIN : PORT_INST;
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: registered-grant arbiter between the instruction and main
// cacheline adaptors and one shared backing memory. A grant covers exactly one
// BURST_LEN-beat burst; op and address are latched at grant so the burst
// cannot be retargeted. One dead IDLE cycle separates consecutive bursts.
// Build option: PMEM_ARB_ROUND_ROBIN_EN (tie policy, see pmem_arb_grant).
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   {inst,main}_read/_write       level request strobes, held until final resp
//   {inst,main}_addr/_wdata       line address / current write beat
//   {inst,main}_rdata/_resp       broadcast read beat / per-port beat handshake
//   pmem_read/_write/_addr/_wdata memory request (from latched op/addr)
//   pmem_rdata/_resp              memory read beat / beat handshake
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inst_read,
  input  logic              inst_write,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_resp,
  input  logic              main_read,
  input  logic              main_write,
  input  logic [ADDR_W-1:0] main_addr,
  input  logic [DATA_W-1:0] main_wdata,
  output logic [DATA_W-1:0] main_rdata,
  output logic              main_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  arb_state_t        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;

  logic      w_req_inst, w_req_main, w_grant_en, w_last_beat, w_busy;
  arb_port_t w_winner;

  assign w_req_inst = inst_read | inst_write;
  assign w_req_main = main_read | main_write;
  assign w_grant_en = (r_state == ARB_IDLE) && (w_req_inst || w_req_main);
  assign w_last_beat = pmem_resp && (r_cnt == CW'(BURST_LEN - 1));

  pmem_arb_grant u_grant (
    .CLK        (CLK),
    .RST        (RST),
    .i_req_inst (w_req_inst),
    .i_req_main (w_req_main),
    .i_grant_en (w_grant_en),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        // pmem_resp in IDLE is deliberately ignored (counter untouched).
        if (w_grant_en) begin
          w_state_nxt = port2state(w_winner);
          w_cnt_nxt   = '0;
        end
      end
      ARB_INST, ARB_MAIN: begin
        if (w_last_beat) begin
          w_state_nxt = ARB_IDLE;
          w_cnt_nxt   = '0;
        end else if (pmem_resp) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant_en) begin
        // Both strobes high counts as a write.
        r_op_wr <= (w_winner == PORT_MAIN) ? main_write : inst_write;
        r_addr  <= (w_winner == PORT_MAIN) ? main_addr  : inst_addr;
      end
    end
  end

  // Request side comes from latched op/addr; only wdata follows the live
  // granted requester so each write beat is supplied as it is accepted.
  assign w_busy     = (r_state != ARB_IDLE);
  assign pmem_read  = w_busy && !r_op_wr;
  assign pmem_write = w_busy &&  r_op_wr;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = (r_state == ARB_MAIN) ? main_wdata : inst_wdata;

  assign inst_resp  = (r_state == ARB_INST) && pmem_resp;
  assign main_resp  = (r_state == ARB_MAIN) && pmem_resp;
  assign inst_rdata = pmem_rdata;
  assign main_rdata = pmem_rdata;

endmodule
